// File: rtl/v810_tagstore_if.sv
// Lookup, fill and clear request/response bundle between cache controller and tag store.
interface v810_tagstore_if #(
  parameter int IDX_W = 7,
  parameter int TAG_W = 22
);
  logic             lu_valid;
  logic [IDX_W-1:0] lu_index;
  logic [TAG_W-1:0] lu_tag;
  logic             lu_ready;
  logic             rsp_valid;
  logic             rsp_hit;
  logic             rsp_way;
  logic             fill_en;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_way;
  logic             clr_start;
  logic [IDX_W-1:0] clr_index;
  logic [IDX_W:0]   clr_count;
  logic             clr_busy;
  logic             clr_done;

  modport master (
    output lu_valid, lu_index, lu_tag, fill_en, fill_index, fill_tag,
           clr_start, clr_index, clr_count,
    input  lu_ready, rsp_valid, rsp_hit, rsp_way, fill_way, clr_busy, clr_done
  );

  modport slave (
    input  lu_valid, lu_index, lu_tag, fill_en, fill_index, fill_tag,
           clr_start, clr_index, clr_count,
    output lu_ready, rsp_valid, rsp_hit, rsp_way, fill_way, clr_busy, clr_done
  );
endinterface

// File: rtl/v810_tagstore.sv
// Set-associative tag store with valid/LRU flops and bulk clear; lookup result 1 cycle after accept.
// Lookups and fills stall (lu_ready=0) while the clear sequencer runs; requester holds its request.
module v810_tagstore #(
  parameter int WAYS  = 2,
  parameter int IDX_W = 7,
  parameter int TAG_W = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  v810_tagstore_if.slave  bus
);
  localparam int SETS = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W:0]   rem_q, rem_d;

  logic [TAG_W-1:0] tag_mem [WAYS][SETS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [SETS-1:0]  lru_q;

  logic lu_acc, fill_acc, hit_any, hit_way, victim;

  assign bus.lu_ready = (state_q != CLEAR);
  assign bus.clr_busy = (state_q == CLEAR);
  assign bus.clr_done = (state_q == DONE);
  assign lu_acc       = bus.lu_valid & bus.lu_ready;
  assign fill_acc     = bus.fill_en & bus.lu_ready;
  assign victim       = (WAYS == 2) ? lru_q[bus.fill_index] : 1'b0;

  // Lowest matching way wins; duplicate tags in a set are a controller error.
  always_comb begin
    hit_any = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[bus.lu_index][w] && (tag_mem[w][bus.lu_index] == bus.lu_tag)) begin
        if (!hit_any) hit_way = 1'(w);
        hit_any = 1'b1;
      end
    end
  end

  // Tag RAM has no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (fill_acc) tag_mem[victim][bus.fill_index] <= bus.fill_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      lru_q <= '0;
    end else begin
      if (state_q == CLEAR) begin
        valid_q[cur_q] <= '0;
        lru_q[cur_q]   <= 1'b0;
      end
      if (lu_acc && hit_any && (WAYS == 2)) lru_q[bus.lu_index] <= ~hit_way;
      // Fill comes last so its LRU update overrides a same-set hit.
      if (fill_acc) begin
        valid_q[bus.fill_index][victim] <= 1'b1;
        if (WAYS == 2) lru_q[bus.fill_index] <= ~victim;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_way   <= 1'b0;
      bus.fill_way  <= 1'b0;
    end else begin
      bus.rsp_valid <= lu_acc;
      bus.rsp_hit   <= lu_acc & hit_any;
      bus.rsp_way   <= lu_acc & hit_any & hit_way;
      if (fill_acc) bus.fill_way <= victim;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          cur_d   = bus.clr_index;
          rem_d   = bus.clr_count;
          state_d = (bus.clr_count == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        cur_d = cur_q + IDX_W'(1);
        rem_d = rem_q - (IDX_W + 1)'(1);
        if (rem_q == (IDX_W + 1)'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_v810_tagstore.sv
// Directed stimulus with scoreboard queues; a negedge monitor checks every response and fill way.
module tb_v810_tagstore;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  v810_tagstore_if #(.IDX_W(7), .TAG_W(22)) bus ();

  v810_tagstore #(.WAYS(2), .IDX_W(7), .TAG_W(22)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] exp_rsp_q [$];
  logic       exp_fill_q [$];
  logic       fill_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected results whenever the DUT presents them.
  always @(negedge clk) begin
    logic [1:0] e;
    logic       ew;
    if (!rst_n) begin
      fill_pend = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_hit_way", {30'd0, bus.rsp_hit, bus.rsp_way}, {30'd0, e});
        end
      end
      if (fill_pend) begin
        if (exp_fill_q.size() == 0) begin
          chk("unexpected_fill", 32'd1, 32'd0);
        end else begin
          ew = exp_fill_q.pop_front();
          chk("fill_way", {31'd0, bus.fill_way}, {31'd0, ew});
        end
      end
      fill_pend = bus.fill_en && bus.lu_ready;
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.lu_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_lookup(input logic [6:0] idx, input logic [21:0] tag,
                           input logic hit, input logic way);
    exp_rsp_q.push_back({hit, way});
    bus.lu_valid = 1'b1; bus.lu_index = idx; bus.lu_tag = tag;
    wait_ready("lookup");
    @(posedge clk); #1;
    bus.lu_valid = 1'b0;
  endtask

  task automatic do_fill(input logic [6:0] idx, input logic [21:0] tag, input logic way);
    exp_fill_q.push_back(way);
    bus.fill_en = 1'b1; bus.fill_index = idx; bus.fill_tag = tag;
    wait_ready("fill");
    @(posedge clk); #1;
    bus.fill_en = 1'b0;
  endtask

  task automatic do_clear(input logic [6:0] idx, input logic [7:0] cnt, input int exp_busy);
    int busy = 0;
    int done = 0;
    bus.clr_start = 1'b1; bus.clr_index = idx; bus.clr_count = cnt;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.clr_done) begin done = 1; break; end
      if (bus.clr_busy) busy++;
    end
    chk("clr_busy_cycles", busy, exp_busy);
    chk("clr_done_seen", done, 1);
    @(posedge clk); #1;
    chk("clr_done_one_cycle", {31'd0, bus.clr_done}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.lu_valid = 1'b0; bus.fill_en = 1'b0; bus.clr_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.lu_index = '0; bus.lu_tag = '0; bus.fill_index = '0; bus.fill_tag = '0;
    bus.clr_index = '0; bus.clr_count = '0;
    do_reset();

    // 1: reset values and a cold miss
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_hit",   {31'd0, bus.rsp_hit},   32'd0);
    chk("rst_rsp_way",   {31'd0, bus.rsp_way},   32'd0);
    chk("rst_fill_way",  {31'd0, bus.fill_way},  32'd0);
    chk("rst_clr_busy",  {31'd0, bus.clr_busy},  32'd0);
    chk("rst_clr_done",  {31'd0, bus.clr_done},  32'd0);
    chk("rst_lu_ready",  {31'd0, bus.lu_ready},  32'd1);
    do_lookup(7'd5, 22'h1234, 1'b0, 1'b0);

    // 2: two fills, hit makes way0 the victim, third fill evicts 0x1234
    do_fill(7'd5, 22'h1234, 1'b0);
    do_fill(7'd5, 22'h0ABC, 1'b1);
    do_lookup(7'd5, 22'h0ABC, 1'b1, 1'b1);
    do_fill(7'd5, 22'h0777, 1'b0);
    do_lookup(7'd5, 22'h1234, 1'b0, 1'b0);
    do_lookup(7'd5, 22'h0777, 1'b1, 1'b0);
    do_lookup(7'd5, 22'h0ABC, 1'b1, 1'b1);

    // 3: same-cycle fill and lookup: lookup sees pre-fill state
    exp_fill_q.push_back(1'b0);
    exp_rsp_q.push_back(2'b00);
    bus.fill_en = 1'b1; bus.fill_index = 7'd3; bus.fill_tag = 22'h55;
    bus.lu_valid = 1'b1; bus.lu_index = 7'd3; bus.lu_tag = 22'h55;
    wait_ready("combo");
    @(posedge clk); #1;
    bus.fill_en = 1'b0; bus.lu_valid = 1'b0;
    do_lookup(7'd3, 22'h55, 1'b1, 1'b0);

    // 4: fill every set, clear a window that wraps past the top
    repeat (3) @(posedge clk);
    do_reset();
    for (int s = 0; s < 128; s++) begin
      do_fill(7'(s), 22'(s), 1'b0);
      do_fill(7'(s), 22'(s) + 22'h1000, 1'b1);
    end
    do_clear(7'd126, 8'd4, 4);
    do_lookup(7'd126, 22'd126, 1'b0, 1'b0);
    do_lookup(7'd127, 22'd127 + 22'h1000, 1'b0, 1'b0);
    do_lookup(7'd0, 22'd0, 1'b0, 1'b0);
    do_lookup(7'd1, 22'd1 + 22'h1000, 1'b0, 1'b0);
    do_lookup(7'd2, 22'd2, 1'b1, 1'b0);
    do_lookup(7'd2, 22'd2 + 22'h1000, 1'b1, 1'b1);
    do_lookup(7'd125, 22'd125, 1'b1, 1'b0);

    // 5: zero-count clear changes nothing
    do_clear(7'd50, 8'd0, 0);
    do_lookup(7'd50, 22'd50 + 22'h1000, 1'b1, 1'b1);
    do_lookup(7'd2, 22'd2, 1'b1, 1'b0);

    // 5b: full clear with a lookup held throughout
    begin
      int busy = 0, rdy_bad = 0, rsp_bad = 0, done = 0;
      bus.clr_start = 1'b1; bus.clr_index = 7'd0; bus.clr_count = 8'd128;
      @(posedge clk); #1;
      bus.clr_start = 1'b0;
      exp_rsp_q.push_back(2'b00);
      bus.lu_valid = 1'b1; bus.lu_index = 7'd2; bus.lu_tag = 22'd2;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (bus.clr_done) begin done = 1; break; end
        if (bus.clr_busy) busy++;
        if (bus.lu_ready) rdy_bad++;
        if (bus.rsp_valid) rsp_bad++;
      end
      chk("full_clr_busy_cycles", busy, 128);
      chk("full_clr_done", done, 1);
      chk("held_lu_ready_low", rdy_bad, 0);
      chk("held_no_rsp", rsp_bad, 0);
      @(posedge clk); #1;
      bus.lu_valid = 1'b0;
    end
    do_lookup(7'd77, 22'd77, 1'b0, 1'b0);

    // 6: reset in the middle of a 64-set clear
    do_fill(7'd100, 22'h3AB, 1'b0);
    do_fill(7'd1, 22'h111, 1'b0);
    do_fill(7'd1, 22'h222, 1'b1);
    do_lookup(7'd100, 22'h3AB, 1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    bus.clr_start = 1'b1; bus.clr_index = 7'd0; bus.clr_count = 8'd64;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midclr_busy", {31'd0, bus.clr_busy}, 32'd1);
    do_reset();
    begin
      int bad = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (bus.clr_done || bus.clr_busy) bad++;
      end
      chk("post_rst_no_done_busy", bad, 0);
    end
    @(posedge clk); #1;
    do_lookup(7'd100, 22'h3AB, 1'b0, 1'b0);
    do_lookup(7'd1, 22'h111, 1'b0, 1'b0);
    do_lookup(7'd1, 22'h222, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    chk("rsp_queue_drained", exp_rsp_q.size(), 0);
    chk("fill_queue_drained", exp_fill_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
